// File: rtl/mem_ctrl.sv
// Byte-serial memory controller sitting behind the load/store buffer.
// Arbitrates instruction fetch against LSB loads/stores, serializes each
// access onto the 8-bit RAM port and returns the assembled, extended result
// with a one-cycle done pulse. Reads abort on a ROB flush; committed stores
// always complete. Stores to IO space wait while the UART buffer is full.
module mem_ctrl #(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = 32'h0003_0000
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              lsb_req,
  input  logic              lsb_we,
  input  logic [2:0]        lsb_func3,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_done,
  output logic [31:0]       lsb_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  localparam logic GRANT_IF  = 1'b0;
  localparam logic GRANT_LSB = 1'b1;

  localparam logic [2:0] FUNC3_W = 3'b010;

  logic [1:0]        state;
  logic [2:0]        cnt;        // bytes already handled in this access
  logic [2:0]        len_q;      // access size in bytes: 1, 2 or 4
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        func3_q;
  logic [31:0]       wdata_q;
  logic              who_q;      // requester that owns the current access
  logic              last_grant;
  logic [31:0]       buf_q;      // read bytes assembled little-endian

  logic              if_cand;
  logic              lsb_cand;
  logic              pick_lsb;
  logic [2:0]        next_cnt;
  logic [ADDR_W-1:0] byte_addr;
  logic [ADDR_W-1:0] next_addr;
  logic              io_hit;

  // Byte count from the low two func3 bits; 2'b11 is not a legal size.
  function automatic logic [2:0] size_of(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Sign/zero extension of an assembled load according to func3.
  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // A flush cancels reads presented in the same cycle; committed stores survive it.
  assign if_cand  = if_req && !clear_in;
  assign lsb_cand = lsb_req && (!clear_in || lsb_we);

  // Address arithmetic wraps naturally at ADDR_W bits.
  assign next_cnt  = cnt + 3'd1;
  assign byte_addr = addr_q + ADDR_W'(cnt);
  assign next_addr = addr_q + ADDR_W'(next_cnt);
  assign io_hit    = (addr_q >= IO_BASE);

  // Round-robin: on a tie the requester not served last time wins.
  always_comb begin
    // NOTE: combinational outputs get a default first so no latch is inferred.
    pick_lsb = 1'b0;
    if (lsb_cand && (!if_cand || last_grant == GRANT_IF)) pick_lsb = 1'b1;
  end

  // Access sequencer: grant, byte serialization, result delivery.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees pre-edge values regardless of statement order.
    if (!rst_n_in) begin
      state      <= S_IDLE;
      cnt        <= 3'd0;
      len_q      <= 3'd0;
      addr_q     <= '0;
      func3_q    <= 3'd0;
      wdata_q    <= 32'h0;
      who_q      <= GRANT_IF;
      last_grant <= GRANT_IF;
      buf_q      <= 32'h0;
      mem_a      <= '0;
      mem_dout   <= 8'h0;
      mem_wr     <= 1'b0;
      if_done    <= 1'b0;
      if_data    <= 32'h0;
      lsb_done   <= 1'b0;
      lsb_rdata  <= 32'h0;
    end else if (!rdy_in) begin
      // Frozen: only the write strobe is dropped so no byte is repeated.
      mem_wr <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      lsb_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (if_cand || lsb_cand) begin
            who_q      <= pick_lsb;
            last_grant <= pick_lsb;
            addr_q     <= pick_lsb ? lsb_addr : if_addr;
            mem_a      <= pick_lsb ? lsb_addr : if_addr;
            func3_q    <= pick_lsb ? lsb_func3 : FUNC3_W;
            len_q      <= pick_lsb ? size_of(lsb_func3[1:0]) : 3'd4;
            wdata_q    <= lsb_wdata;
            mem_wr     <= 1'b0;
            cnt        <= 3'd0;
            buf_q      <= 32'h0;
            state      <= (pick_lsb && lsb_we) ? S_WRITE : S_READ;
          end
        end
        S_READ: begin
          if (clear_in) begin
            mem_wr <= 1'b0;
            state  <= S_IDLE;
          end else if (cnt == len_q) begin
            if (who_q == GRANT_LSB) begin
              lsb_done  <= 1'b1;
              lsb_rdata <= extend(func3_q, buf_q);
            end else begin
              if_done <= 1'b1;
              if_data <= buf_q;
            end
            state <= S_IDLE;
          end else begin
            // mem_din answers the address presented on the previous edge.
            buf_q[{cnt[1:0], 3'b000} +: 8] <= mem_din;
            if (next_cnt < len_q) mem_a <= next_addr;
            cnt <= next_cnt;
          end
        end
        S_WRITE: begin
          if (cnt == len_q) begin
            mem_wr   <= 1'b0;
            mem_a    <= '0;
            lsb_done <= 1'b1;
            state    <= S_IDLE;
          end else if (io_hit && io_buffer_full) begin
            mem_wr <= 1'b0;
          end else begin
            mem_wr   <= 1'b1;
            mem_a    <= byte_addr;
            mem_dout <= wdata_q[{cnt[1:0], 3'b000} +: 8];
            cnt      <= next_cnt;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-addressed RAM behind the DUT, a
// separate reference memory for expected results, directed scenarios from
// the access rules, a round-robin run and a randomized access mix.
module tb_mem_ctrl;

  localparam logic [31:0] IO_BASE = 32'h0003_0000;
  localparam int          MEM_SZ  = 262144;

  logic        clk_in;
  logic        rst_n_in;
  logic        rdy_in;
  logic        clear_in;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_req;
  logic        lsb_we;
  logic [2:0]  lsb_func3;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;

  int n_pass  = 0;
  int n_total = 0;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  mem_ctrl dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .rdy_in         (rdy_in),
    .clear_in       (clear_in),
    .io_buffer_full (io_buffer_full),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_done        (if_done),
    .if_data        (if_data),
    .lsb_req        (lsb_req),
    .lsb_we         (lsb_we),
    .lsb_func3      (lsb_func3),
    .lsb_addr       (lsb_addr),
    .lsb_wdata      (lsb_wdata),
    .lsb_done       (lsb_done),
    .lsb_rdata      (lsb_rdata)
  );

  // Power-on RAM contents, with the bytes the directed loads rely on.
  function automatic logic [7:0] init_byte(input logic [17:0] a);
    case (a)
      18'h00100: return 8'h11;
      18'h00101: return 8'h22;
      18'h00102: return 8'h33;
      18'h00103: return 8'h44;
      18'h00200: return 8'h80;
      default:   return 8'((a * 18'd37) ^ (a >> 5) ^ 18'h0005A);
    endcase
  endfunction

  // RAM attached to the DUT: read data valid during the cycle after the address.
  logic [7:0] ram       [MEM_SZ];
  bit         ram_valid [MEM_SZ];
  assign mem_din = ram_valid[mem_a[17:0]] ? ram[mem_a[17:0]] : init_byte(mem_a[17:0]);

  always @(posedge clk_in) begin
    if (mem_wr) begin
      ram[mem_a[17:0]]       <= mem_dout;
      ram_valid[mem_a[17:0]] <= 1'b1;
    end
  end

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram_valid[a[17:0]] ? ram[a[17:0]] : init_byte(a[17:0]);
  endfunction

  // Reference memory: what the RAM should hold after each completed access.
  logic [7:0] ref_mem [MEM_SZ];

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // Expected load value: little-endian value of N bytes, minus 2^(8N) when signed and negative.
  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] f3);
    int          n;
    logic [31:0] val;
    logic [31:0] t;
    n   = size_of(f3);
    val = 32'h0;
    for (int i = 0; i < n; i++) begin
      t   = addr + 32'(i);
      val = val + (32'(ref_mem[t[17:0]]) << (8 * i));
    end
    if (!f3[2] && n < 4 && val >= (32'h1 << (8 * n - 1))) val = val - (32'h1 << (8 * n));
    return val;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One access from a requester, checked edge by edge. rdy_lo: first of two
  // edges with rdy_in low (-1 none); stall_n: io_buffer_full high on edges
  // 1..stall_n; clr_at: edge carrying clear_in (-1 none). Starts at a negedge.
  task automatic access(input bit is_if, input bit we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int rdy_lo, input int stall_n, input int clr_at);
    int          n;
    int          j;
    bit          abort;
    bit          frz;
    bit          finished;
    logic        done_v;
    logic [31:0] data_v;
    logic [31:0] exp_data;
    logic [31:0] prev_a;
    logic [31:0] t;
    n        = is_if ? 4 : size_of(f3);
    exp_data = ref_load(addr, is_if ? 3'b010 : f3);
    abort    = !we && clr_at >= 1;
    finished = 1'b0;
    j        = 0;
    if (is_if) begin
      if_req  = 1'b1;
      if_addr = addr;
    end else begin
      lsb_req   = 1'b1;
      lsb_we    = we;
      lsb_func3 = f3;
      lsb_addr  = addr;
      lsb_wdata = wd;
    end
    prev_a = mem_a;
    for (int e = 0; e < 40; e++) begin
      rdy_in         = !(rdy_lo >= 0 && e >= rdy_lo && e < rdy_lo + 2);
      io_buffer_full = (e >= 1 && e <= stall_n);
      clear_in       = (e == clr_at);
      if (abort && e == clr_at) begin
        if_req  = 1'b0;
        lsb_req = 1'b0;
      end
      frz = !rdy_in || (clear_in && !we && j == 0) ||
            (we && addr >= IO_BASE && io_buffer_full && j >= 1 && j <= n);
      @(negedge clk_in);
      done_v = is_if ? if_done : lsb_done;
      data_v = is_if ? if_data : lsb_rdata;
      if (abort && e >= clr_at) begin
        check("abort_no_done", done_v, 1'b0);
        check("abort_wr", mem_wr, 1'b0);
        if (e == clr_at + 5) begin
          finished = 1'b1;
          break;
        end
      end else if (frz) begin
        check("hold_wr", mem_wr, 1'b0);
        check("hold_addr", mem_a, prev_a);
        check("hold_done", done_v, 1'b0);
      end else begin
        if (we && j >= 1 && j <= n) begin
          t = addr + 32'(j - 1);
          check("wr_strobe", mem_wr, 1'b1);
          check("wr_addr", mem_a, t);
          check("wr_byte", mem_dout, (wd >> (8 * (j - 1))) & 32'hFF);
          check("wr_done", done_v, 1'b0);
        end else if (we && j == n + 1) begin
          check("wr_end_strobe", mem_wr, 1'b0);
          check("wr_end_addr", mem_a, 32'h0);
          check("wr_end_done", done_v, 1'b1);
        end else begin
          check("rd_strobe", mem_wr, 1'b0);
          if (!we && j < n) check("rd_addr", mem_a, addr + 32'(j));
          check("done_timing", done_v, (j == n + 1) ? 1'b1 : 1'b0);
          if (!we && j == n + 1) check(is_if ? "if_data" : "lsb_rdata", data_v, exp_data);
        end
        if (j == n + 1) begin
          finished = 1'b1;
          break;
        end
        j++;
      end
      prev_a = mem_a;
    end
    check("completed", finished, 1'b1);
    if_req         = 1'b0;
    lsb_req        = 1'b0;
    clear_in       = 1'b0;
    io_buffer_full = 1'b0;
    rdy_in         = 1'b1;
    @(negedge clk_in);
    check("pulse_len", is_if ? if_done : lsb_done, 1'b0);
    if (we) begin
      for (int i = 0; i < n; i++) begin
        t = addr + 32'(i);
        ref_mem[t[17:0]] = 8'(wd >> (8 * i));
      end
    end
  endtask

  task automatic reset_checks;
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_dout", mem_dout, 32'h0);
    check("rst_mem_wr", mem_wr, 1'b0);
    check("rst_if_done", if_done, 1'b0);
    check("rst_lsb_done", lsb_done, 1'b0);
    check("rst_if_data", if_data, 32'h0);
    check("rst_lsb_rdata", lsb_rdata, 32'h0);
  endtask

  logic [2:0]  f3_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [31:0] a_if;
  logic [31:0] a_ls;
  logic [31:0] r_addr;
  logic [2:0]  r_f3;
  bit          r_if;
  bit          r_we;
  bit          next_lsb;
  bit          seen_done;
  int          r_rdy;
  int          got;
  int          mism;

  initial begin
    for (int i = 0; i < MEM_SZ; i++) ref_mem[i] = init_byte(18'(i));
    rst_n_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = 32'h0; lsb_req = 1'b0; lsb_we = 1'b0;
    lsb_func3 = 3'b000; lsb_addr = 32'h0; lsb_wdata = 32'h0;
    repeat (3) @(negedge clk_in);
    reset_checks();
    rst_n_in = 1'b1;
    @(negedge clk_in);

    // Directed accesses.
    access(1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'h0, -1, 0, -1);          // LW
    access(1'b0, 1'b0, 3'b000, 32'h0000_0200, 32'h0, -1, 0, -1);          // LB
    access(1'b0, 1'b0, 3'b100, 32'h0000_0200, 32'h0, -1, 0, -1);          // LBU
    access(1'b0, 1'b1, 3'b001, 32'h0000_0300, 32'hABCD_1234, -1, 0, -1);  // SH
    check("sh_ram_lo", ram_rd(32'h300), 8'h34);
    check("sh_ram_hi", ram_rd(32'h301), 8'h12);
    access(1'b0, 1'b1, 3'b001, 32'h0000_0310, 32'h0000_8001, -1, 0, -1);  // SH negative
    access(1'b0, 1'b0, 3'b001, 32'h0000_0310, 32'h0, -1, 0, -1);          // LH
    access(1'b0, 1'b0, 3'b101, 32'h0000_0310, 32'h0, -1, 0, -1);          // LHU
    access(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, -1, 0, 2);           // fetch flushed
    access(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, -1, 0, -1);          // fetch
    access(1'b0, 1'b1, 3'b010, 32'h0000_0320, 32'hDEAD_BEEF, -1, 0, 2);   // SW ignores flush
    access(1'b0, 1'b0, 3'b010, 32'h0000_0320, 32'h0, -1, 0, 0);           // load dropped by flush, then granted
    access(1'b0, 1'b1, 3'b000, IO_BASE, 32'h0000_005A, -1, 3, -1);        // IO store stalled
    check("io_ram", ram_rd(IO_BASE), 8'h5A);
    access(1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 2, 0, -1);           // LW with rdy low
    access(1'b0, 1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, -1, 0, -1);          // wrapping, misaligned
    access(1'b0, 1'b1, 3'b010, 32'h0000_0333, 32'h0102_0304, -1, 0, -1);  // misaligned SW
    access(1'b0, 1'b0, 3'b010, 32'h0000_0333, 32'h0, -1, 0, -1);

    // Reset in the middle of a load: outputs clear at once, no done afterwards.
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_func3 = 3'b010; lsb_addr = 32'h0000_0104;
    repeat (2) @(negedge clk_in);
    #2 rst_n_in = 1'b0;
    #1 reset_checks();
    lsb_req = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    seen_done = 1'b0;
    repeat (6) begin
      @(negedge clk_in);
      seen_done = seen_done | lsb_done | if_done;
    end
    check("rst_abandon", seen_done, 1'b0);

    // Both requesters held: service alternates, starting with the LSB.
    a_if = 32'($urandom_range(0, 1023));
    a_ls = 32'($urandom_range(0, 1023));
    if_req = 1'b1; if_addr = a_if;
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_func3 = 3'b010; lsb_addr = a_ls;
    next_lsb = 1'b1;
    got = 0;
    for (int e = 0; e < 80 && got < 6; e++) begin
      @(negedge clk_in);
      if (lsb_done || if_done) begin
        check("arb_order", lsb_done, next_lsb);
        if (lsb_done) begin
          check("arb_lsb_data", lsb_rdata, ref_load(a_ls, 3'b010));
          a_ls = 32'($urandom_range(0, 1023));
          lsb_addr = a_ls;
        end
        if (if_done) begin
          check("arb_if_data", if_data, ref_load(a_if, 3'b010));
          a_if = 32'($urandom_range(0, 1023));
          if_addr = a_if;
        end
        next_lsb = !next_lsb;
        got++;
      end
    end
    check("arb_count", got, 6);
    if_req = 1'b0; lsb_req = 1'b0;
    repeat (2) @(negedge clk_in);

    // Randomized mix of fetches, loads and stores.
    for (int k = 0; k < 40; k++) begin
      r_if   = ($urandom_range(0, 3) == 0);
      r_we   = !r_if && ($urandom_range(0, 1) == 1);
      r_f3   = f3_tab[$urandom_range(0, r_we ? 2 : 4)];
      r_addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      r_rdy  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : -1;
      access(r_if, r_we, r_f3, r_addr, $urandom, r_rdy, 0, -1);
    end

    mism = 0;
    for (int i = 0; i < 1024; i++) if (ram_rd(32'(i)) !== ref_mem[i]) mism++;
    check("ram_image", mism, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
